// File: rtl/dccm_ctrl.sv
// DCCM storage plus port controller: LSU read/write ports with a side-band
// debug/preload port that borrows the array only on LSU-idle cycles.
module dccm_ctrl #(
   parameter int              XLEN       = 32,
   parameter int              DCCM_DEPTH = 1024,
   parameter logic [XLEN-1:0] DCCM_BASE  = 32'h0001_0000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [XLEN-1:0] lsu_dccm_raddr,
   input  logic            lsu_dccm_rvalid_in,
   output logic [XLEN-1:0] lsu_dccm_rdata,
   output logic            lsu_dccm_rvalid_out,
   input  logic [XLEN-1:0] lsu_dccm_waddr,
   input  logic            lsu_dccm_wen,
   input  logic [XLEN-1:0] lsu_dccm_wdata,
   input  logic            dbg_req,
   input  logic            dbg_we,
   input  logic [XLEN-1:0] dbg_addr,
   input  logic [XLEN-1:0] dbg_wdata,
   output logic            dbg_gnt,
   output logic [XLEN-1:0] dbg_rdata,
   output logic            dbg_rvalid,
   output logic            dccm_addr_err
);

   localparam int              IDX_W = $clog2(DCCM_DEPTH);
   localparam logic [XLEN-1:0] SPAN  = XLEN'(DCCM_DEPTH) << 2;

   typedef enum logic [1:0] {S_IDLE, S_GNT, S_RESP} dbg_state_t;

   dbg_state_t state;

   logic [XLEN-1:0] mem [DCCM_DEPTH];

   logic [XLEN-1:0]  r_off, w_off, d_off;
   logic             r_in, w_in, d_in;
   logic [IDX_W-1:0] r_idx, w_idx, d_idx;
   logic             lsu_busy, dbg_rd, dbg_wr;
   logic             wr_en;
   logic [IDX_W-1:0] wr_idx, rd_idx;
   logic [XLEN-1:0]  wr_data, rd_word;
   logic             rd_in;

   // Address decode: offsets from the base wrap, so one unsigned compare covers both bounds.
   assign r_off = lsu_dccm_raddr - DCCM_BASE;
   assign w_off = lsu_dccm_waddr - DCCM_BASE;
   assign d_off = dbg_addr - DCCM_BASE;
   assign r_in  = r_off < SPAN;
   assign w_in  = w_off < SPAN;
   assign d_in  = d_off < SPAN;
   assign r_idx = r_off[IDX_W+1:2];
   assign w_idx = w_off[IDX_W+1:2];
   assign d_idx = d_off[IDX_W+1:2];

   // The LSU always owns the port; debug only goes through when the LSU is quiet this cycle.
   assign lsu_busy = lsu_dccm_rvalid_in | lsu_dccm_wen;
   assign dbg_gnt  = (state == S_GNT) & ~lsu_busy;
   assign dbg_rd   = dbg_gnt & ~dbg_we;
   assign dbg_wr   = dbg_gnt & dbg_we;

   // Single read and single write port muxing, with write-first bypass on an index match.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      wr_en   = 1'b0;
      wr_idx  = d_idx;
      wr_data = dbg_wdata;
      rd_idx  = d_idx;
      rd_in   = d_in;
      rd_word = '0;
      if (lsu_dccm_wen) begin
         wr_en   = w_in;
         wr_idx  = w_idx;
         wr_data = lsu_dccm_wdata;
      end else if (dbg_wr) begin
         wr_en   = d_in;
      end
      if (lsu_dccm_rvalid_in) begin
         rd_idx = r_idx;
         rd_in  = r_in;
      end
      if (rd_in) begin
         rd_word = (wr_en && (wr_idx == rd_idx)) ? wr_data : mem[rd_idx];
      end
   end

   // Array write port.
   // NOTE: the storage array has no reset; only control and output registers are cleared.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   // LSU response registers; rdata only moves on a new read so the LSU can re-sample it.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n) begin
         lsu_dccm_rdata      <= '0;
         lsu_dccm_rvalid_out <= 1'b0;
         dccm_addr_err       <= 1'b0;
      end else begin
         lsu_dccm_rvalid_out <= lsu_dccm_rvalid_in;
         if (lsu_dccm_rvalid_in) begin
            lsu_dccm_rdata <= rd_word;
         end
         dccm_addr_err <= (lsu_dccm_rvalid_in & ~r_in) | (lsu_dccm_wen & ~w_in) |
                          (dbg_gnt & ~d_in);
      end
   end

   // Debug FSM: wait for a quiet port, hold the grant until it really happens, then respond.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         dbg_rdata  <= '0;
         dbg_rvalid <= 1'b0;
      end else begin
         dbg_rvalid <= dbg_rd;
         if (dbg_rd) begin
            dbg_rdata <= rd_word;
         end
         case (state)
            S_IDLE: if (dbg_req && !lsu_busy) state <= S_GNT;
            S_GNT:  if (!lsu_busy) state <= dbg_we ? S_IDLE : S_RESP;
            S_RESP: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
